// File: rtl/imem_responder.sv
// Instruction-memory responder: queues fetch addresses from the IF stage,
// issues in-order reads to the backing memory, returns instruction words with
// one cycle of latency, and supports flushing queued and in-flight fetches.
module imem_responder #(
    parameter int ADDR_LEN = 32,
    parameter int INSN_LEN = 32,
    parameter int DEPTH    = 4
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [ADDR_LEN-1:0] iaddr_i,
    input  logic                ireq_i,
    input  logic                kill_i,
    output logic                stall_o,
    output logic [INSN_LEN-1:0] idata_o,
    output logic                ivalid_o,
    output logic                mem_req_o,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [INSN_LEN-1:0] mem_rdata_i
);

    // Pointer index width; pointers carry one extra wrap bit on top of it.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counter width: must be able to hold the value DEPTH itself.
    localparam int CW = PW + 1;

    logic [ADDR_LEN-1:0] fifo_mem [DEPTH];
    logic [PW:0]         wr_ptr;
    logic [PW:0]         rd_ptr;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       discard;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic rsp;
    logic [ADDR_LEN-1:0] head_addr;

    // Queue status, handshakes and the memory-side request derived from the head entry.
    always_comb begin
        empty      = (wr_ptr == rd_ptr);
        full       = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
        push       = ireq_i && !full && !kill_i;
        mem_req_o  = !empty && !kill_i && (outstanding < CW'(DEPTH));
        pop        = mem_req_o && mem_gnt_i;
        rsp        = mem_rvalid_i && (outstanding != '0);
        head_addr  = fifo_mem[rd_ptr[PW-1:0]];
        mem_addr_o = {head_addr[ADDR_LEN-1:2], 2'b00};
        stall_o    = full;
    end

    // Address storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= iaddr_i;
        end
    end

    // Queue pointers; a flush empties the queue by snapping the read pointer to the write pointer.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (kill_i) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // In-flight read count; responses with nothing in flight are ignored entirely.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CW'(pop) - CW'(rsp);
        end
    end

    // Number of stale responses still to be swallowed after a flush.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            discard <= '0;
        end else if (kill_i) begin
            discard <= outstanding - CW'(rsp);
        end else if (rsp && (discard != '0)) begin
            discard <= discard - 1'b1;
        end
    end

    // Registered response path: forward live read data, suppress stale or flushed data.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            idata_o  <= '0;
            ivalid_o <= 1'b0;
        end else if (kill_i) begin
            idata_o  <= '0;
            ivalid_o <= 1'b0;
        end else if (rsp && (discard == '0)) begin
            idata_o  <= mem_rdata_i;
            ivalid_o <= 1'b1;
        end else begin
            ivalid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: transaction-level reference model
// with a response scoreboard drained by an independent monitor.
module tb_imem_responder;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [31:0] iaddr_i = '0;
    logic        ireq_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        stall_o;
    logic [31:0] idata_o;
    logic        ivalid_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    typedef struct {
        logic [31:0] addr;
        bit          dead;
    } rd_t;

    logic [31:0] addr_q[$];
    rd_t         mem_q[$];
    logic [31:0] exp_q[$];
    bit          last_exp_valid = 1'b0;
    bit          last_kill = 1'b0;
    int          checks = 0;
    int          errors = 0;

    imem_responder #(.ADDR_LEN(32), .INSN_LEN(32), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .iaddr_i     (iaddr_i),
        .ireq_i      (ireq_i),
        .kill_i      (kill_i),
        .stall_o     (stall_o),
        .idata_o     (idata_o),
        .ivalid_o    (ivalid_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory contents as a pure function of the word address.
    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h8000_0013;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response the DUT presents must match the oldest expected word.
    always @(negedge clk_i) begin
        if (reset_ni && ivalid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ivalid: got data %h with no response expected at %0t", idata_o, $time);
            end else begin
                checkOutput("idata", idata_o, exp_q.pop_front());
            end
        end
    end

    // One clock cycle: drive inputs, check combinational outputs and latency, advance the model.
    task automatic applyStimulus(input bit t_req, input logic [31:0] t_addr, input bit t_kill,
                                 input bit t_gnt, input bit t_rv);
        bit exp_full;
        bit exp_req;
        bit exp_valid;
        rd_t e;
        @(negedge clk_i);
        ireq_i       = t_req;
        iaddr_i      = t_addr;
        kill_i       = t_kill;
        mem_gnt_i    = t_gnt;
        mem_rvalid_i = t_rv;
        mem_rdata_i  = (t_rv && mem_q.size() > 0) ? data_of(mem_q[0].addr) : $urandom;
        #1;
        checkOutput("ivalid_latency", {31'b0, ivalid_o}, {31'b0, last_exp_valid});
        if (last_kill) begin
            checkOutput("idata_after_kill", idata_o, 32'h0);
        end
        exp_full = (addr_q.size() == DEPTH);
        exp_req  = (addr_q.size() > 0) && !t_kill && (mem_q.size() < DEPTH);
        checkOutput("stall", {31'b0, stall_o}, {31'b0, exp_full});
        checkOutput("mem_req", {31'b0, mem_req_o}, {31'b0, exp_req});
        if (exp_req) begin
            checkOutput("mem_addr", mem_addr_o, addr_q[0] & 32'hFFFF_FFFC);
        end
        exp_valid = 1'b0;
        if (t_rv && mem_q.size() > 0) begin
            e = mem_q.pop_front();
            if (!e.dead && !t_kill) begin
                exp_q.push_back(data_of(e.addr));
                exp_valid = 1'b1;
            end
        end
        if (t_kill) begin
            addr_q.delete();
            foreach (mem_q[i]) mem_q[i].dead = 1'b1;
        end else begin
            if (exp_req && t_gnt) begin
                e.addr = addr_q.pop_front() & 32'hFFFF_FFFC;
                e.dead = 1'b0;
                mem_q.push_back(e);
            end
            if (t_req && !exp_full) begin
                addr_q.push_back(t_addr);
            end
        end
        last_exp_valid = exp_valid;
        last_kill      = t_kill;
    endtask

    // Asynchronous reset between clock edges; outputs must clear immediately.
    task automatic applyReset();
        @(posedge clk_i);
        #3;
        reset_ni     = 1'b0;
        ireq_i       = 1'b0;
        kill_i       = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        #1;
        checkOutput("rst_ivalid", {31'b0, ivalid_o}, 32'h0);
        checkOutput("rst_idata", idata_o, 32'h0);
        checkOutput("rst_stall", {31'b0, stall_o}, 32'h0);
        checkOutput("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
        addr_q.delete();
        mem_q.delete();
        exp_q.delete();
        last_exp_valid = 1'b0;
        last_kill      = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((addr_q.size() > 0 || mem_q.size() > 0) && n < 100) begin
            applyStimulus(0, 32'h0, 0, 1, 1);
            n++;
        end
        if (addr_q.size() > 0 || mem_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d queued %0d in flight after %0d cycles", addr_q.size(), mem_q.size(), n);
        end
        applyStimulus(0, 32'h0, 0, 0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0);
    endtask

    initial begin
        applyReset();

        // Single fetch, granted at once, data two cycles later.
        applyStimulus(1, 32'h8000_0000, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 0, 0);
        applyStimulus(0, 32'h0, 0, 0, 1);
        applyStimulus(0, 32'h0, 0, 0, 0);
        checkOutput("first_idata", idata_o, 32'h0000_0013);

        // Fill the queue with no grants, then drain in order.
        applyStimulus(1, 32'h0, 0, 0, 0);
        applyStimulus(1, 32'h4, 0, 0, 0);
        applyStimulus(1, 32'h8, 0, 0, 0);
        applyStimulus(1, 32'hC, 0, 0, 0);
        applyStimulus(1, 32'h10, 0, 0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 0, 1, 0);
        drain();

        // Flush with three reads in flight; stale data must be swallowed.
        applyStimulus(1, 32'h200, 0, 1, 0);
        applyStimulus(1, 32'h204, 0, 1, 0);
        applyStimulus(1, 32'h208, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 0, 0, 1);
        applyStimulus(1, 32'h100, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 0, 1);
        applyStimulus(0, 32'h0, 0, 0, 0);

        // Flush coinciding with a response while two reads are in flight.
        applyStimulus(1, 32'h300, 0, 1, 0);
        applyStimulus(1, 32'h304, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 1, 0, 1);
        applyStimulus(0, 32'h0, 0, 0, 1);
        applyStimulus(1, 32'h308, 0, 1, 0);
        drain();

        // Response with nothing in flight is ignored.
        applyStimulus(0, 32'h0, 0, 0, 1);
        applyStimulus(0, 32'h0, 0, 0, 0);

        // Randomized traffic with occasional flushes and unaligned addresses.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 1) == 1,
                          (mem_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0));
        end
        drain();

        // Reset mid-operation with two reads in flight; late responses ignored.
        applyStimulus(1, 32'h400, 0, 1, 0);
        applyStimulus(1, 32'h404, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyReset();
        applyStimulus(0, 32'h0, 0, 0, 1);
        applyStimulus(0, 32'h0, 0, 0, 1);
        applyStimulus(1, 32'h500, 0, 1, 0);
        drain();

        checkOutput("pending_responses", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
